// File: rtl/free_list.sv
// ============================================================================
// free_list : circular FIFO of free physical-register numbers, 2 alloc / 2 free
// Rev 1.0
// ============================================================================
`default_nettype none

module free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PREG_W    = $clog2(NUM_PREGS),
    parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [1:0]             i_alloc_req,
    output logic [1:0][PREG_W-1:0] o_alloc_preg,
    output logic [1:0]             o_alloc_valid,
    output logic                   o_stall,
    input  logic [1:0]             i_free_valid,
    input  logic [1:0][PREG_W-1:0] i_free_preg,
    output logic [CNT_W-1:0]       o_free_count,
    output logic                   o_error
);

    localparam logic [PTR_W:0]   c_DEPTH_P = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH_C = CNT_W'(DEPTH);

    logic [PREG_W-1:0] fifo_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              error_q, error_d;

    logic [1:0]        w_n_req;
    logic [1:0]        w_grant;
    logic [1:0]        w_n_grant;
    logic [CNT_W-1:0]  w_after_pop;
    logic [CNT_W-1:0]  w_space;
    logic [1:0]        w_ok;
    logic              w_acc0, w_acc1;
    logic [1:0]        w_n_acc;
    logic [PREG_W-1:0] w_wdat0;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W + 1)'(n);
        if (s >= c_DEPTH_P) begin
            s = s - c_DEPTH_P;
        end
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        w_n_req   = {1'b0, i_alloc_req[0]} + {1'b0, i_alloc_req[1]};
        o_stall   = !i_rst && (CNT_W'(w_n_req) > count_q);
        w_grant   = (i_rst || o_stall) ? 2'b00 : i_alloc_req;
        w_n_grant = {1'b0, w_grant[0]} + {1'b0, w_grant[1]};
        o_alloc_valid   = w_grant;
        o_alloc_preg[0] = fifo_q[head_q];
        o_alloc_preg[1] = fifo_q[ptr_add(head_q, {1'b0, i_alloc_req[0]})];

        // Frees fill whatever room is left after this cycle's pops, in slot order.
        w_after_pop = count_q - CNT_W'(w_n_grant);
        w_space     = c_DEPTH_C - w_after_pop;
        w_ok[0]     = i_free_valid[0] && (i_free_preg[0] != '0);
        w_ok[1]     = i_free_valid[1] && (i_free_preg[1] != '0);
        w_acc0      = w_ok[0] && (w_space != '0);
        w_acc1      = w_ok[1] && ((w_space - CNT_W'(w_acc0)) != '0);
        w_n_acc     = {1'b0, w_acc0} + {1'b0, w_acc1};
        w_wdat0     = w_acc0 ? i_free_preg[0] : i_free_preg[1];

        head_d  = ptr_add(head_q, w_n_grant);
        tail_d  = ptr_add(tail_q, w_n_acc);
        count_d = w_after_pop + CNT_W'(w_n_acc);
        error_d = error_q
                | (i_free_valid[0] && (i_free_preg[0] == '0))
                | (i_free_valid[1] && (i_free_preg[1] == '0))
                | (w_ok[0] && !w_acc0)
                | (w_ok[1] && !w_acc1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= PREG_W'(NUM_AREGS + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= c_DEPTH_C;
            error_q <= 1'b0;
        end else begin
            if (w_acc0 || w_acc1) begin
                fifo_q[tail_q] <= w_wdat0;
            end
            if (w_acc0 && w_acc1) begin
                fifo_q[ptr_add(tail_q, 2'd1)] <= i_free_preg[1];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign o_free_count = count_q;
    assign o_error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_free_list.sv
// ============================================================================
// tb_free_list : randomized self-checking bench with a queue-based reference
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_free_list;

    localparam int DEPTH = 32;

    logic            clk;
    logic            rst;
    logic [1:0]      alloc_req;
    logic [1:0][5:0] alloc_preg;
    logic [1:0]      alloc_valid;
    logic            stall;
    logic [1:0]      free_valid;
    logic [1:0][5:0] free_preg;
    logic [5:0]      free_count;
    logic            error;

    free_list dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_alloc_req  (alloc_req),
        .o_alloc_preg (alloc_preg),
        .o_alloc_valid(alloc_valid),
        .o_stall      (stall),
        .i_free_valid (free_valid),
        .i_free_preg  (free_preg),
        .o_free_count (free_count),
        .o_error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    int q[$];       // reference free list, front = next to allocate
    int pool[$];    // pregs currently handed out, source of legal frees
    bit m_err;
    int obs0, obs1, obs_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pool.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(32 + i);
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        alloc_req  = 2'b00;
        free_valid = 2'b00;
        free_preg  = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive at negedge, check combinational/registered outputs, update model.
    task automatic cycle(input logic [1:0] req, input logic [1:0] fv, input int f0, input int f1);
        int  nreq;
        bit  exp_stall;
        int  e0, e1;
        alloc_req    = req;
        free_valid   = fv;
        free_preg[0] = 6'(f0);
        free_preg[1] = 6'(f1);
        #1;
        nreq      = int'(req[0]) + int'(req[1]);
        exp_stall = nreq > q.size();
        e0 = (q.size() > 0) ? q[0] : 0;
        e1 = req[0] ? ((q.size() > 1) ? q[1] : 0) : e0;
        obs0    = int'(alloc_preg[0]);
        obs1    = int'(alloc_preg[1]);
        obs_cnt = int'(free_count);
        check("stall", 32'(stall), 32'(exp_stall));
        check("valid", 32'(alloc_valid), exp_stall ? 32'd0 : 32'(req));
        if (!exp_stall && req[0]) check("preg0", 32'(obs0), 32'(e0));
        if (!exp_stall && req[1]) check("preg1", 32'(obs1), 32'(e1));
        check("count", 32'(obs_cnt), 32'(q.size()));
        check("error", 32'(error), 32'(m_err));
        @(posedge clk);
        if (!exp_stall) begin
            for (int k = 0; k < nreq; k++) pool.push_back(q.pop_front());
        end
        for (int k = 0; k < 2; k++) begin
            if (fv[k]) begin
                int p;
                p = (k == 0) ? f0 : f1;
                if (p == 0) m_err = 1'b1;
                else if (q.size() < DEPTH) q.push_back(p);
                else m_err = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    function automatic int take_pool();
        int idx;
        int p;
        idx = $urandom_range(pool.size() - 1);
        p   = pool[idx];
        pool.delete(idx);
        return p;
    endfunction

    initial begin
        int prev;
        rst        = 1'b1;
        alloc_req  = 2'b00;
        free_valid = 2'b00;
        free_preg  = '0;
        model_reset();
        #2;
        check("rst_count", 32'(free_count), 32'd32);
        check("rst_valid", 32'(alloc_valid), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // dual grant straight out of reset
        cycle(2'b11, 2'b00, 0, 0);
        check("tp1_p0", 32'(obs0), 32'd32);
        check("tp1_p1", 32'(obs1), 32'd33);
        cycle(2'b00, 2'b00, 0, 0);
        check("tp1_cnt", 32'(obs_cnt), 32'd30);

        // slot 1 alone takes the head
        do_reset();
        cycle(2'b10, 2'b00, 0, 0);
        check("tp2_p1", 32'(obs1), 32'd32);
        cycle(2'b01, 2'b00, 0, 0);
        check("tp2_next", 32'(obs0), 32'd33);

        // drain to one, all-or-nothing stall, then empty
        do_reset();
        for (int i = 0; i < 15; i++) cycle(2'b11, 2'b00, 0, 0);
        cycle(2'b01, 2'b00, 0, 0);
        cycle(2'b11, 2'b00, 0, 0);
        check("tp3_stall_cnt", 32'(obs_cnt), 32'd1);
        cycle(2'b01, 2'b00, 0, 0);
        check("tp3_last", 32'(obs0), 32'd63);
        cycle(2'b01, 2'b11, 5, 7);
        check("tp4_empty_cnt", 32'(obs_cnt), 32'd0);
        cycle(2'b01, 2'b00, 0, 0);
        check("tp4_p5", 32'(obs0), 32'd5);
        check("tp4_cnt2", 32'(obs_cnt), 32'd2);
        cycle(2'b01, 2'b00, 0, 0);
        check("tp4_p7", 32'(obs0), 32'd7);
        check("tp4_cnt1", 32'(obs_cnt), 32'd1);

        // steady alloc/free pairs to wrap head and tail
        do_reset();
        cycle(2'b01, 2'b00, 0, 0);
        prev = obs0;
        for (int i = 0; i < 40; i++) begin
            cycle(2'b01, 2'b01, prev, 0);
            prev = obs0;
        end
        cycle(2'b00, 2'b00, 0, 0);
        check("wrap_cnt", 32'(obs_cnt), 32'd31);
        check("wrap_err", 32'(error), 32'd0);

        // overflow at full, sticky error
        do_reset();
        cycle(2'b00, 2'b01, 9, 0);
        cycle(2'b00, 2'b00, 0, 0);
        check("ovf_err", 32'(error), 32'd1);
        check("ovf_cnt", 32'(obs_cnt), 32'd32);
        cycle(2'b01, 2'b00, 0, 0);
        check("ovf_sticky", 32'(error), 32'd1);

        // freeing P0
        do_reset();
        cycle(2'b11, 2'b00, 0, 0);
        cycle(2'b00, 2'b10, 0, 0);
        cycle(2'b00, 2'b00, 0, 0);
        check("p0_err", 32'(error), 32'd1);
        check("p0_cnt", 32'(obs_cnt), 32'd30);

        // mid-stream asynchronous reset
        rst       = 1'b1;
        alloc_req = 2'b11;
        #1;
        check("mrst_valid", 32'(alloc_valid), 32'd0);
        check("mrst_stall", 32'(stall), 32'd0);
        check("mrst_cnt", 32'(free_count), 32'd32);
        check("mrst_err", 32'(error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(2'b01, 2'b00, 0, 0);
        check("mrst_first", 32'(obs0), 32'd32);

        // random legal traffic: frees come only from pregs handed out
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [1:0] r;
            logic [1:0] fv;
            int a, b;
            r  = 2'($urandom);
            fv = 2'b00;
            a  = 0;
            b  = 0;
            if (pool.size() > 0 && ($urandom_range(2) != 0)) begin fv[0] = 1'b1; a = take_pool(); end
            if (pool.size() > 0 && ($urandom_range(2) != 0)) begin fv[1] = 1'b1; b = take_pool(); end
            cycle(r, fv, a, b);
        end
        check("rand_err", 32'(error), 32'd0);

        // random junk frees: P0, duplicates and overflow
        for (int i = 0; i < 150; i++) begin
            cycle(2'($urandom), 2'($urandom), $urandom_range(63), $urandom_range(63));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical-register numbers.
- Sits between the retire output of the ROB/complete stage and the rename stage.
- Rename pulls up to 2 new destination pregs per cycle. Retire returns up to 2 superseded pregs (OldPRegAddrDst of retiring rows with RegWrite) per cycle.
- All-or-nothing allocation, with stall back-pressure to rename.

Parameters:
- NUM_PREGS, 64, total physical registers.
- NUM_AREGS, 32, architectural registers; P0..P(NUM_AREGS-1) are mapped at reset, so they are never initially free.
- PREG_W, 6, width of a preg number (= clog2(NUM_PREGS)).
- DEPTH, NUM_PREGS-NUM_AREGS (32), FIFO capacity.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_alloc_req  in  2  bit k = rename slot k needs a destination preg this cycle.
- o_alloc_preg  out  2 x PREG_W  preg granted to slot 0/1 (combinational).
- o_alloc_valid  out  2  bit k = o_alloc_preg[k] is valid and consumed at next edge.
- o_stall  out  1  requests exceed available entries; nothing granted.
- i_free_valid  in  2  bit k = retire slot k returns a preg.
- i_free_preg  in  2 x PREG_W  preg numbers being returned.
- o_free_count  out  clog2(DEPTH+1)  registered number of free entries.
- o_error  out  1  sticky flag: overflow, or an attempt to free P0.

Behaviour:
- State:
  - array fifo[0:DEPTH-1] of PREG_W;
  - head and tail pointers, clog2(DEPTH) bits, wrapping modulo DEPTH;
  - count register;
  - error register.
- Reset (async, any time, including mid-operation):
  - fifo[i] = NUM_AREGS+i;
  - head = 0, tail = 0, count = DEPTH, error = 0.
  - While i_rst is high, outputs are o_alloc_valid = 0, o_stall = 0, o_free_count = DEPTH, o_error = 0.
- Allocation (combinational, 0-cycle latency so rename uses the preg in the same cycle):
  - n_req = popcount(i_alloc_req).
  - If n_req <= count: grant all requests.
    - Slot 0 (if requested) gets fifo[head].
    - Slot 1 gets fifo[head + i_alloc_req[0]], modulo DEPTH.
  - If n_req > count: o_stall = 1, o_alloc_valid = 0, nothing consumed.
  - No partial grant.
  - Unrequested slots: o_alloc_valid = 0, o_alloc_preg = don't care.
- Pop: on the edge, head advances by the number of grants, modulo DEPTH.
- Free (registered, 1-cycle):
  - Valid frees are compacted in slot order.
  - First valid free is written to fifo[tail], second to fifo[tail+1], modulo DEPTH.
  - tail advances by the number of accepted frees.
- P0 never enters the list:
  - A free of preg 0 is dropped and sets error.
- Same-cycle interaction:
  - Frees presented this cycle are not allocatable this cycle; count used for grants is the registered value.
  - Simultaneous grant and free: count_next = count - grants + accepted_frees.
  - A simultaneous alloc and free at full or empty is legal: count is bounded by the registered value, so no same-cycle bypass is needed.
- Overflow:
  - If count - grants + frees > DEPTH, accept frees in slot order only up to capacity.
  - Drop the rest and set error.
  - Error is sticky until reset.
- Wrap-around: any pointer increment crossing DEPTH-1 wraps to 0, including +2 from DEPTH-2 and DEPTH-1.
- o_free_count = count register (not the same-cycle next value).

Test Plan:
- Reset, then i_alloc_req=2'b11 for one cycle -> o_alloc_preg = {32,33}, valid = 2'b11; next cycle o_free_count = 30.
- i_alloc_req=2'b10 only (slot 1) right after reset -> slot 1 gets 32, o_alloc_valid = 2'b10; next grant starts at 33.
- Drain to count=1, then request 2'b11 -> o_stall=1, o_alloc_valid=0, count stays 1. Then request 2'b01 -> preg 63 granted, count=0.
- At count=0, free {5,7} with i_free_valid=2'b11 while requesting 2'b01 -> stall that cycle. Next cycle the request is granted preg 5 and count goes 2 -> 1. Then the next grant is 7.
- Run 40 alloc/free pairs so head and tail wrap past 31 -> FIFO order is preserved across the wrap, count stays constant, o_error stays 0.
- At count=DEPTH, free preg 9 -> dropped, o_error=1 and stays high. Free preg 0 after reset -> o_error=1. Assert i_rst mid-stream -> all state returns to its reset values immediately.
